// File: rtl/game_round_ctrl.sv
// Timed game round sequencer: 1 Hz prescaler, ready countdown, pausable play
// window, hit scoring with saturation and a session high score.
module game_round_ctrl #(
    parameter int TICK_DIV      = 100000000,
    parameter int READY_SECONDS = 3,
    parameter int PLAY_SECONDS  = 30,
    parameter int SEC_W         = 6,
    parameter int SCORE_W       = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               hit,
    output logic [2:0]         state,
    output logic [SEC_W-1:0]   seconds_left,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               playing,
    output logic               round_done,
    output logic               tick
);

    // state   | meaning
    // IDLE    | waiting for start, prescaler stopped
    // READY   | pre-round countdown, hits ignored
    // PLAY    | play window running, hits scored
    // PAUSE   | play window frozen, prescaler holds
    // OVER    | round finished, waiting for start
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam int                 PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]      PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SEC_W-1:0]   READY_SEC = SEC_W'(READY_SECONDS);
    localparam logic [SEC_W-1:0]   PLAY_SEC  = SEC_W'(PLAY_SECONDS);
    localparam logic [SEC_W-1:0]   SEC_ONE   = SEC_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t             r_state;
    logic [PW-1:0]      r_presc;
    logic [SEC_W-1:0]   r_sec;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_high;
    logic               r_playing;
    logic               r_done;
    logic               r_tick;

    logic               w_running;
    logic               w_tick_evt;
    logic               w_last_sec;
    logic [SCORE_W-1:0] w_score_inc;
    logic [SCORE_W-1:0] w_score_hit;

    assign w_running   = (r_state == ST_READY) || (r_state == ST_PLAY);
    assign w_tick_evt  = w_running && (r_presc == PRESC_MAX);
    assign w_last_sec  = (r_sec == SEC_ONE);
    assign w_score_inc = (r_score == SCORE_MAX) ? r_score : r_score + 1'b1;
    // Score including a hit in this cycle, so a hit on the final tick still counts
    assign w_score_hit = (r_state == ST_PLAY && hit) ? w_score_inc : r_score;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_sec     <= '0;
            r_score   <= '0;
            r_high    <= '0;
            r_playing <= 1'b0;
            r_done    <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_tick <= w_tick_evt;
            if (w_running) begin
                r_presc <= w_tick_evt ? '0 : r_presc + 1'b1;
            end

            case (r_state)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        r_state <= ST_READY;
                        r_sec   <= READY_SEC;
                        r_score <= '0;
                        r_presc <= '0;
                    end
                end
                ST_READY: begin
                    if (w_tick_evt) begin
                        if (w_last_sec) begin
                            r_state   <= ST_PLAY;
                            r_sec     <= PLAY_SEC;
                            r_playing <= 1'b1;
                        end else begin
                            r_sec <= r_sec - 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    r_score <= w_score_hit;
                    if (w_tick_evt && w_last_sec) begin
                        r_state   <= ST_OVER;
                        r_sec     <= '0;
                        r_playing <= 1'b0;
                        r_done    <= 1'b1;
                        if (w_score_hit > r_high) begin
                            r_high <= w_score_hit;
                        end
                    end else begin
                        if (w_tick_evt) begin
                            r_sec <= r_sec - 1'b1;
                        end
                        if (pause) begin
                            r_state   <= ST_PAUSE;
                            r_playing <= 1'b0;
                        end
                    end
                end
                ST_PAUSE: begin
                    // Abort wins over resume if both arrive together
                    if (start) begin
                        r_state <= ST_IDLE;
                        r_sec   <= '0;
                    end else if (pause) begin
                        r_state   <= ST_PLAY;
                        r_playing <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_playing <= 1'b0;
                end
            endcase
        end
    end

    assign state        = r_state;
    assign seconds_left = r_sec;
    assign score        = r_score;
    assign high_score   = r_high;
    assign playing      = r_playing;
    assign round_done   = r_done;
    assign tick         = r_tick;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl: one 8-bit-score instance for round flow,
// pause and reset, one 3-bit-score instance for saturation and final-tick hits.
module tb_game_round_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic       m_start = 1'b0, m_pause = 1'b0, m_hit = 1'b0;
    logic [2:0] m_state;
    logic [5:0] m_sec;
    logic [7:0] m_score, m_high;
    logic       m_playing, m_done, m_tick;

    logic       s_start = 1'b0, s_pause = 1'b0, s_hit = 1'b0;
    logic [2:0] s_state;
    logic [5:0] s_sec;
    logic [2:0] s_score, s_high;
    logic       s_playing, s_done, s_tick;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clock = ~clock;

    game_round_ctrl #(
        .TICK_DIV(4), .READY_SECONDS(3), .PLAY_SECONDS(5), .SEC_W(6), .SCORE_W(8)
    ) dut (
        .clock(clock), .reset(reset), .start(m_start), .pause(m_pause), .hit(m_hit),
        .state(m_state), .seconds_left(m_sec), .score(m_score), .high_score(m_high),
        .playing(m_playing), .round_done(m_done), .tick(m_tick)
    );

    game_round_ctrl #(
        .TICK_DIV(4), .READY_SECONDS(3), .PLAY_SECONDS(5), .SEC_W(6), .SCORE_W(3)
    ) dut_s (
        .clock(clock), .reset(reset), .start(s_start), .pause(s_pause), .hit(s_hit),
        .state(s_state), .seconds_left(s_sec), .score(s_score), .high_score(s_high),
        .playing(s_playing), .round_done(s_done), .tick(s_tick)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Hold the given inputs of one instance for n edges, then release them
    task automatic drive(input bit sel, input bit st, input bit pa, input bit ht, input int n);
        if (sel) begin
            s_start = st; s_pause = pa; s_hit = ht;
        end else begin
            m_start = st; m_pause = pa; m_hit = ht;
        end
        clk(n);
        m_start = 1'b0; m_pause = 1'b0; m_hit = 1'b0;
        s_start = 1'b0; s_pause = 1'b0; s_hit = 1'b0;
    endtask

    task automatic tick_chk(input string tag, input bit sel, input int exp_wait);
        int waited;
        waited = 0;
        for (int i = 1; i <= 64 && waited == 0; i++) begin
            clk(1);
            if ((sel ? s_tick : m_tick) == 1'b1) waited = i;
        end
        if (waited == 0) chk({tag, "_timeout"}, 0, 1);
        else chk(tag, waited, exp_wait);
    endtask

    task automatic to_play(input string tag, input bit sel);
        drive(sel, 1'b1, 1'b0, 1'b0, 1);
        tick_chk({tag, "_rt1"}, sel, 4);
        tick_chk({tag, "_rt2"}, sel, 4);
        tick_chk({tag, "_rt3"}, sel, 4);
    endtask

    initial begin
        int cnt;
        #1 reset = 1'b0;
        #1;
        chk("rst_state", m_state, 0);
        chk("rst_sec", m_sec, 0);
        chk("rst_score", m_score, 0);
        chk("rst_high", m_high, 0);
        chk("rst_flags", {m_playing, m_done, m_tick}, 0);
        clk(2);
        reset = 1'b1;
        clk(7);

        // Round 1: countdown, 7 hits across the window
        drive(0, 1'b1, 1'b0, 1'b0, 1);
        chk("r1_state_ready", m_state, 1);
        chk("r1_sec_ready", m_sec, 3);
        chk("r1_score_clr", m_score, 0);
        tick_chk("r1_rt1", 0, 4);
        chk("r1_sec_2", m_sec, 2);
        tick_chk("r1_rt2", 0, 4);
        chk("r1_sec_1", m_sec, 1);
        tick_chk("r1_rt3", 0, 4);
        chk("r1_state_play", m_state, 2);
        chk("r1_sec_play", m_sec, 5);
        chk("r1_playing", m_playing, 1);
        drive(0, 1'b0, 1'b0, 1'b1, 2);
        tick_chk("r1_pt1", 0, 2);
        chk("r1_sec_p4", m_sec, 4);
        chk("r1_score_2", m_score, 2);
        drive(0, 1'b0, 1'b0, 1'b1, 3);
        tick_chk("r1_pt2", 0, 1);
        chk("r1_sec_p3", m_sec, 3);
        chk("r1_score_5", m_score, 5);
        drive(0, 1'b0, 1'b0, 1'b1, 2);
        tick_chk("r1_pt3", 0, 2);
        chk("r1_score_7", m_score, 7);
        tick_chk("r1_pt4", 0, 4);
        chk("r1_sec_p1", m_sec, 1);
        tick_chk("r1_pt5", 0, 4);
        chk("r1_state_over", m_state, 4);
        chk("r1_sec_over", m_sec, 0);
        chk("r1_done", m_done, 1);
        chk("r1_high", m_high, 7);
        chk("r1_playing_off", m_playing, 0);
        clk(1);
        chk("r1_done_pulse", m_done, 0);
        chk("r1_over_hold", m_state, 4);
        chk("r1_no_tick_over", m_tick, 0);

        // Round 2: pause mid-second with hit held, resume, 3 hits total
        drive(0, 1'b1, 1'b0, 1'b0, 1);
        chk("r2_score_clr", m_score, 0);
        chk("r2_state_ready", m_state, 1);
        tick_chk("r2_rt1", 0, 4);
        tick_chk("r2_rt2", 0, 4);
        tick_chk("r2_rt3", 0, 4);
        drive(0, 1'b0, 1'b0, 1'b1, 1);
        drive(0, 1'b0, 1'b1, 1'b0, 1);
        chk("r2_state_pause", m_state, 3);
        chk("r2_playing_pause", m_playing, 0);
        m_hit = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            clk(1);
            if (m_tick) cnt++;
        end
        m_hit = 1'b0;
        chk("r2_pause_ticks", cnt, 0);
        chk("r2_pause_score", m_score, 1);
        chk("r2_pause_sec", m_sec, 5);
        chk("r2_pause_state", m_state, 3);
        drive(0, 1'b0, 1'b1, 1'b0, 1);
        chk("r2_resume", m_state, 2);
        chk("r2_resume_playing", m_playing, 1);
        tick_chk("r2_resume_tick", 0, 2);
        chk("r2_sec_4", m_sec, 4);
        drive(0, 1'b0, 1'b0, 1'b1, 2);
        tick_chk("r2_pt2", 0, 2);
        chk("r2_score_3", m_score, 3);
        tick_chk("r2_pt3", 0, 4);
        tick_chk("r2_pt4", 0, 4);
        tick_chk("r2_pt5", 0, 4);
        chk("r2_state_over", m_state, 4);
        chk("r2_done", m_done, 1);
        chk("r2_high_kept", m_high, 7);

        // Round 3: pause on a non-final tick, 9 hits, new high score
        drive(0, 1'b1, 1'b0, 1'b0, 1);
        chk("r3_score_clr", m_score, 0);
        tick_chk("r3_rt1", 0, 4);
        tick_chk("r3_rt2", 0, 4);
        tick_chk("r3_rt3", 0, 4);
        drive(0, 1'b0, 1'b0, 1'b1, 3);
        drive(0, 1'b0, 1'b1, 1'b0, 1);
        chk("r3_ptick_state", m_state, 3);
        chk("r3_ptick_sec", m_sec, 4);
        chk("r3_ptick_tick", m_tick, 1);
        chk("r3_ptick_score", m_score, 3);
        drive(0, 1'b0, 1'b1, 1'b0, 1);
        chk("r3_resume", m_state, 2);
        drive(0, 1'b0, 1'b0, 1'b1, 3);
        tick_chk("r3_pt2", 0, 1);
        chk("r3_sec_3", m_sec, 3);
        chk("r3_score_6", m_score, 6);
        drive(0, 1'b0, 1'b0, 1'b1, 3);
        tick_chk("r3_pt3", 0, 1);
        chk("r3_score_9", m_score, 9);
        tick_chk("r3_pt4", 0, 4);
        tick_chk("r3_pt5", 0, 4);
        chk("r3_state_over", m_state, 4);
        chk("r3_done", m_done, 1);
        chk("r3_high", m_high, 9);

        // Abort from PAUSE keeps score, high score untouched
        to_play("r4", 0);
        drive(0, 1'b0, 1'b0, 1'b1, 1);
        drive(0, 1'b0, 1'b1, 1'b0, 1);
        chk("r4_state_pause", m_state, 3);
        drive(0, 1'b1, 1'b0, 1'b0, 1);
        chk("r4_abort_state", m_state, 0);
        chk("r4_abort_sec", m_sec, 0);
        chk("r4_abort_score", m_score, 1);
        chk("r4_abort_high", m_high, 9);
        chk("r4_abort_done", m_done, 0);

        // Asynchronous reset mid-PLAY
        to_play("r5", 0);
        drive(0, 1'b0, 1'b0, 1'b1, 3);
        tick_chk("r5_pt1", 0, 1);
        tick_chk("r5_pt2", 0, 4);
        tick_chk("r5_pt3", 0, 4);
        chk("r5_pre_score", m_score, 3);
        chk("r5_pre_sec", m_sec, 2);
        #3 reset = 1'b0;
        #1;
        chk("r5_rst_state", m_state, 0);
        chk("r5_rst_sec", m_sec, 0);
        chk("r5_rst_score", m_score, 0);
        chk("r5_rst_high", m_high, 0);
        chk("r5_rst_flags", {m_playing, m_done, m_tick}, 0);
        #1 reset = 1'b1;
        clk(2);

        // 3-bit score: hit together with the final tick, then saturation
        to_play("s1", 1);
        drive(1, 1'b0, 1'b0, 1'b1, 4);
        chk("s1_tick_on_hit", s_tick, 1);
        chk("s1_sec_4", s_sec, 4);
        chk("s1_score_4", s_score, 4);
        tick_chk("s1_pt2", 1, 4);
        tick_chk("s1_pt3", 1, 4);
        tick_chk("s1_pt4", 1, 4);
        clk(3);
        chk("s1_last_state", s_state, 2);
        chk("s1_last_sec", s_sec, 1);
        drive(1, 1'b0, 1'b0, 1'b1, 1);
        chk("s1_state_over", s_state, 4);
        chk("s1_final_score", s_score, 5);
        chk("s1_final_high", s_high, 5);
        chk("s1_done", s_done, 1);

        to_play("s2", 1);
        chk("s2_score_clr", s_score, 0);
        drive(1, 1'b0, 1'b0, 1'b1, 10);
        chk("s2_sat", s_score, 7);
        chk("s2_sec", s_sec, 3);
        tick_chk("s2_pt3", 1, 2);
        tick_chk("s2_pt4", 1, 4);
        tick_chk("s2_pt5", 1, 4);
        chk("s2_state_over", s_state, 4);
        chk("s2_high", s_high, 7);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
Sequencer for one timed game round. It derives a 1 Hz tick from the system clock and runs the round through idle, a ready countdown, the play window, pause, and game over. While PLAY is active it counts hits into a score and keeps a session high score. Sits between the debounced button/hit inputs and the display/score logic; it replaces the free-running 30 s window counter with a pausable, restartable round.

Parameters:
TICK_DIV, 100000000, system clocks per one-second tick (>=2)
READY_SECONDS, 3, pre-round countdown length in seconds (>=1)
PLAY_SECONDS, 30, play window length in seconds (>=1, < 2**SEC_W)
SEC_W, 6, width of seconds_left
SCORE_W, 8, width of score and high_score

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse, debounced; begins a round
pause  input  1  single-cycle pulse, debounced; toggles PLAY/PAUSE
hit  input  1  single-cycle pulse; one scoring event
state  output  3  IDLE=0, READY=1, PLAY=2, PAUSE=3, OVER=4
seconds_left  output  SEC_W  remaining seconds of current phase
score  output  SCORE_W  hits in current round
high_score  output  SCORE_W  best score since reset
playing  output  1  high while state==PLAY
round_done  output  1  one-cycle pulse on entry to OVER
tick  output  1  one-cycle pulse each elapsed second (READY/PLAY only)

Behaviour:
- reset (reset==0, asynchronous): state=IDLE, seconds_left=0, score=0, high_score=0, prescaler=0, playing=0, round_done=0, tick=0. All outputs are registered.
- Prescaler: counts 0..TICK_DIV-1 only in READY and PLAY. tick=1 in the cycle after the prescaler holds TICK_DIV-1, then the prescaler wraps to 0. It is cleared to 0 on every entry to READY or PLAY from IDLE/OVER/READY. It holds its value in PAUSE and resumes from that value on return to PLAY.
- IDLE: on start, go to READY; seconds_left=READY_SECONDS; score=0. pause and hit are ignored.
- READY: on tick, if seconds_left==1, go to PLAY with seconds_left=PLAY_SECONDS and prescaler=0; otherwise seconds_left-1. start, pause and hit are ignored.
- PLAY: on hit, score+1, saturating at 2**SCORE_W-1. On tick, if seconds_left==1, go to OVER with seconds_left=0; otherwise seconds_left-1. On pause (without a final tick), go to PAUSE.
- PAUSE: seconds_left and score frozen; hit ignored; tick not generated. On pause, return to PLAY. On start, abort to IDLE with seconds_left=0; score is kept and high_score is not updated.
- OVER: round_done=1 for exactly the entry cycle. In that same cycle, high_score=score if score>high_score. On start, go to READY (same as from IDLE; score cleared). pause and hit are ignored.
- Simultaneous events in PLAY:
  - hit together with the final tick: the hit counts, and high_score compares against the incremented score.
  - pause together with a non-final tick: decrement first, then PAUSE.
  - pause together with the final tick: go to OVER; pause is ignored.
- start in READY or PLAY has no effect.
- Reset asserted mid-round returns immediately to the reset values; high_score is lost.

Test Plan:
- TICK_DIV=4, READY=3, PLAY=5. Reset, then start at cycle 10 -> state=1, seconds_left=3; tick every 4 cycles; seconds_left 3,2,1; PLAY entered on the third tick with seconds_left=5, playing=1.
- In PLAY, 7 hits spread over the window -> score=7; after 5 ticks: state=4, seconds_left=0, round_done high exactly 1 cycle, high_score=7.
- Pause after 2 clocks into a second, hold 20 cycles, pause again -> seconds_left and score frozen, no tick during PAUSE; next tick arrives 2 cycles after resume.
- Second round with 3 hits, then a third with 9 hits -> high_score stays 7 after round 2, becomes 9 after round 3; score cleared to 0 at each start.
- SCORE_W=3, 10 hits -> score saturates at 7. Hit coincident with the final tick at score 4 -> score=5, high_score=5.
- Assert reset mid-PLAY (score 3, seconds_left 2) -> all outputs 0 and state=IDLE immediately, without waiting for a clock edge. start in PAUSE -> state=IDLE, high_score unchanged.
